// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;   // wide enough for MAX_WAIT up to 15

    // Which read response is due on the cycle after a grant
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } resp_state_e;

    // Winner of the shared memory port in the current cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and single-port memory signals.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/addr/we/be/wdata until their gnt.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 12
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Requester and memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear, counts denied fetch cycles.
// Latency: count visible the cycle after an increment.
// Backpressure: none; holds at MAX until cleared.
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment; stop counting once MAX is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory, data-first with anti-starvation.
// Latency: grant combinational; read data returned exactly 1 cycle after the grant.
// Backpressure: loser's req is simply not granted; one access per cycle, no response stall.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    owner_e            w_owner;
    logic [CNT_W-1:0]  w_starve_cnt;
    logic              w_if_prio;
    logic              w_cnt_inc;
    logic              w_cnt_clr;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [BE_W-1:0]   w_mem_be;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    resp_state_e       r_state;
    resp_state_e       w_state_nxt;
    logic              w_if_rvalid;
    logic              w_d_rvalid;
    logic [DATA_W-1:0] w_if_rdata;
    logic [DATA_W-1:0] w_d_rdata;

    // A fetch that has waited MAX_WAIT cycles jumps ahead of data
    assign w_if_prio = bus.if_req && (w_starve_cnt == MAX_CNT);

    // Pick the single winner for this cycle; nobody wins during reset
    always_comb begin
        w_owner = OWN_NONE;
        if (!reset) begin
            if (bus.if_req && (w_if_prio || !bus.d_req)) begin
                w_owner = OWN_IF;
            end else if (bus.d_req) begin
                w_owner = OWN_D;
            end
        end
    end

    assign w_cnt_inc = bus.if_req && (w_owner != OWN_IF);
    assign w_cnt_clr = (w_owner == OWN_IF) || !bus.if_req;

    starve_counter #(
        .MAX (MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_cnt_inc),
        .i_clr (w_cnt_clr),
        .o_cnt (w_starve_cnt)
    );

    // Steer the winner onto the memory port; everything zero when idle
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_be    = '0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (w_owner)
            OWN_IF: begin
                w_mem_en   = 1'b1;
                w_mem_addr = bus.if_addr;
            end
            OWN_D: begin
                w_mem_en    = 1'b1;
                w_mem_we    = bus.d_we;
                w_mem_be    = bus.d_be;
                w_mem_addr  = bus.d_addr;
                w_mem_wdata = bus.d_wdata;
            end
            default: ;
        endcase
    end

    // Response state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next response follows this cycle's read grant; responses are masked during reset
    always_comb begin
        w_state_nxt = IDLE;
        w_if_rvalid = 1'b0;
        w_d_rvalid  = 1'b0;
        w_if_rdata  = '0;
        w_d_rdata   = '0;

        if (w_owner == OWN_IF) begin
            w_state_nxt = RESP_IF;
        end else if ((w_owner == OWN_D) && !bus.d_we) begin
            w_state_nxt = RESP_D;
        end

        if (!reset) begin
            case (r_state)
                RESP_IF: begin
                    w_if_rvalid = 1'b1;
                    w_if_rdata  = bus.mem_rdata;
                end
                RESP_D: begin
                    w_d_rvalid = 1'b1;
                    w_d_rdata  = bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign bus.if_gnt    = (w_owner == OWN_IF);
    assign bus.d_gnt     = (w_owner == OWN_D);
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_be    = w_mem_be;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.if_rvalid = w_if_rvalid;
    assign bus.if_rdata  = w_if_rdata;
    assign bus.d_rvalid  = w_d_rvalid;
    assign bus.d_rdata   = w_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle-read memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mem_loaded = 1'b0;

    logic [31:0] mem [0:DEPTH-1];

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Memory model: preload on the first reset, byte-enabled writes, registered reads
    always @(posedge clk) begin
        if (reset && !mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    task automatic set_idle();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [79:0] memv;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            bus.if_req = 1'b1; bus.if_addr = 12'h004;
            bus.d_req  = 1'b1; bus.d_addr  = 12'h008; bus.d_we = 1'b1;
            bus.d_wdata = 32'h1111_2222; bus.d_be = 4'hF;
            #1;
            n_checks++;
            if ({bus.if_gnt, bus.d_gnt} !== 2'b00) begin
                $display("FAIL reset_gnt: got %b want 00", {bus.if_gnt, bus.d_gnt});
                n_fail++;
            end
            memv = {bus.mem_en, bus.mem_we, bus.mem_be, 2'b00, bus.mem_addr, bus.mem_wdata, 28'h0};
            n_checks++;
            if (memv !== 80'h0) begin
                $display("FAIL reset_mem: got %h want 0", memv);
                n_fail++;
            end
        end
        next_cycle();
        reset = 1'b0;
        set_idle();
        #1;
        n_checks++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata} !== 66'h0) begin
            $display("FAIL reset_resp: got rv=%b%b if=%h d=%h want 0",
                     bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata);
            n_fail++;
        end
        n_checks++;
        if (dut.w_starve_cnt !== 4'd0 || dut.r_state !== IDLE) begin
            $display("FAIL reset_state: got cnt=%0d st=%0d want 0/IDLE", dut.w_starve_cnt, dut.r_state);
            n_fail++;
        end
    endtask

    task automatic test_fetch_only();
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 12'h004;
        #1;
        n_checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we} !== 4'b1010 || bus.mem_addr !== 12'h004) begin
            $display("FAIL fetch_gnt: got gnt=%b%b en=%b we=%b addr=%h want 1 0 1 0 004",
                     bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
            n_fail++;
        end
        next_cycle();
        set_idle();
        #1;
        n_checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== pat(4) || bus.d_rvalid !== 1'b0) begin
            $display("FAIL fetch_resp: got rv=%b data=%h drv=%b want 1 %h 0",
                     bus.if_rvalid, bus.if_rdata, bus.d_rvalid, pat(4));
            n_fail++;
        end
        next_cycle();
        #1;
        n_checks++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0) begin
            $display("FAIL fetch_after: got rv=%b data=%h want 0 0", bus.if_rvalid, bus.if_rdata);
            n_fail++;
        end
    endtask

    task automatic test_starvation();
        logic [1:0]  exp_gnt [4] = '{2'b01, 2'b01, 2'b10, 2'b01};   // {if_gnt, d_gnt}
        logic [1:0]  exp_rv  [4] = '{2'b00, 2'b01, 2'b01, 2'b10};   // {if_rvalid, d_rvalid}
        logic [31:0] exp_dat;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            bus.if_req = (k <= 2); bus.if_addr = 12'h008;
            bus.d_req  = 1'b1;     bus.d_addr  = 12'h020; bus.d_we = 1'b0;
            #1;
            n_checks++;
            if ({bus.if_gnt, bus.d_gnt} !== exp_gnt[k]) begin
                $display("FAIL starve_gnt[%0d]: got %b want %b", k, {bus.if_gnt, bus.d_gnt}, exp_gnt[k]);
                n_fail++;
            end
            exp_dat = exp_rv[k][1] ? pat(8) : (exp_rv[k][0] ? pat(32'h20) : 32'h0);
            n_checks++;
            if ({bus.if_rvalid, bus.d_rvalid} !== exp_rv[k] || (bus.if_rdata | bus.d_rdata) !== exp_dat) begin
                $display("FAIL starve_resp[%0d]: got rv=%b data=%h want %b %h",
                         k, {bus.if_rvalid, bus.d_rvalid}, bus.if_rdata | bus.d_rdata, exp_rv[k], exp_dat);
                n_fail++;
            end
        end
        next_cycle();
        set_idle();
        #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== pat(32'h20) || bus.if_rvalid !== 1'b0) begin
            $display("FAIL starve_tail: got drv=%b d=%h irv=%b want 1 %h 0",
                     bus.d_rvalid, bus.d_rdata, bus.if_rvalid, pat(32'h20));
            n_fail++;
        end
    endtask

    task automatic test_store_load();
        next_cycle();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h010;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'hF;
        #1;
        n_checks++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be} !== 7'b111_1111 ||
            bus.mem_addr !== 12'h010 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
            $display("FAIL store_mem: got gnt=%b en=%b we=%b be=%h addr=%h wd=%h want 1 1 1 f 010 deadbeef",
                     bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
            n_fail++;
        end
        next_cycle();
        bus.d_we = 1'b0; bus.d_wdata = '0; bus.d_be = '0;
        #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b0 || bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
            $display("FAIL store_norv: got rv=%b gnt=%b we=%b want 0 1 0", bus.d_rvalid, bus.d_gnt, bus.mem_we);
            n_fail++;
        end
        next_cycle();
        bus.d_we = 1'b1; bus.d_addr = 12'h011; bus.d_wdata = 32'h1234_5678; bus.d_be = 4'b0011;
        #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL load_back: got rv=%b data=%h want 1 deadbeef", bus.d_rvalid, bus.d_rdata);
            n_fail++;
        end
        next_cycle();
        bus.d_we = 1'b0; bus.d_wdata = '0; bus.d_be = '0;
        #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b0 || bus.mem_be !== 4'h0) begin
            $display("FAIL partial_store_norv: got rv=%b be=%h want 0 0", bus.d_rvalid, bus.mem_be);
            n_fail++;
        end
        next_cycle();
        set_idle();
        #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hA500_5678) begin
            $display("FAIL partial_store: got rv=%b data=%h want 1 a5005678", bus.d_rvalid, bus.d_rdata);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 12'h030;
        #1;
        n_checks++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
            $display("FAIL b2b_gnt0: got %b want 10", {bus.if_gnt, bus.d_gnt});
            n_fail++;
        end
        next_cycle();
        set_idle();
        bus.d_req = 1'b1; bus.d_addr = 12'h040;
        #1;
        n_checks++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b01 || {bus.if_rvalid, bus.d_rvalid} !== 2'b10 ||
            bus.if_rdata !== pat(32'h30)) begin
            $display("FAIL b2b_cyc1: got gnt=%b rv=%b data=%h want 01 10 %h",
                     {bus.if_gnt, bus.d_gnt}, {bus.if_rvalid, bus.d_rvalid}, bus.if_rdata, pat(32'h30));
            n_fail++;
        end
        next_cycle();
        set_idle();
        #1;
        n_checks++;
        if ({bus.if_rvalid, bus.d_rvalid} !== 2'b01 || bus.d_rdata !== pat(32'h40) || bus.if_rdata !== 32'h0) begin
            $display("FAIL b2b_cyc2: got rv=%b d=%h if=%h want 01 %h 0",
                     {bus.if_rvalid, bus.d_rvalid}, bus.d_rdata, bus.if_rdata, pat(32'h40));
            n_fail++;
        end
    endtask

    task automatic test_reset_pending();
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 12'h050;
        bus.d_req  = 1'b1; bus.d_addr  = 12'h060;
        #1;
        n_checks++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
            $display("FAIL rstp_gnt: got %b want 01", {bus.if_gnt, bus.d_gnt});
            n_fail++;
        end
        next_cycle();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en} !== 4'b0000 || bus.d_rdata !== 32'h0) begin
            $display("FAIL rstp_drop: got rv=%b gnt=%b%b en=%b d=%h want 0 00 0 0",
                     bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.d_rdata);
            n_fail++;
        end
        next_cycle();
        reset = 1'b0;
        set_idle();
        bus.d_req = 1'b1; bus.d_addr = 12'h061;
        #1;
        n_checks++;
        if (bus.d_gnt !== 1'b1 || bus.d_rvalid !== 1'b0 || dut.w_starve_cnt !== 4'd0) begin
            $display("FAIL rstp_after: got gnt=%b rv=%b cnt=%0d want 1 0 0",
                     bus.d_gnt, bus.d_rvalid, dut.w_starve_cnt);
            n_fail++;
        end
        next_cycle();
        set_idle();
        #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== pat(32'h61)) begin
            $display("FAIL rstp_resp: got rv=%b d=%h want 1 %h", bus.d_rvalid, bus.d_rdata, pat(32'h61));
            n_fail++;
        end
    endtask

    task automatic test_idle();
        logic [127:0] outs;
        next_cycle();
        set_idle();
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            #1;
            outs = {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                    bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, 10'h0};
            n_checks++;
            if (outs !== 128'h0 || dut.r_state !== IDLE) begin
                $display("FAIL idle[%0d]: got outs=%h st=%0d want 0 IDLE", k, outs, dut.r_state);
                n_fail++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_fetch_only();
        test_starvation();
        test_store_load();
        test_back_to_back();
        test_reset_pending();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: word address width of the shared memory.
REQ-002 Parameter MAX_WAIT, default 2: consecutive denied cycles after which fetch overrides data priority (range 1..15).
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 if_req  input  1  instruction-fetch read request.
REQ-006 if_addr  input  ADDR_W  fetch word address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid.
REQ-009 if_rdata  output  32  fetch read data.
REQ-010 d_req  input  1  data-port request (load or store).
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_W  data word address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_be  input  4  store byte enables.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  load data valid; never asserted for stores.
REQ-017 d_rdata  output  32  load data.
REQ-018 mem_en, mem_we (outputs, 1 bit each), mem_be (output, 4 bits), mem_addr (output, ADDR_W bits), mem_wdata (output, 32 bits), mem_rdata (input, 32 bits): single-port memory with 1-cycle registered read.

Function
REQ-019 Grant is combinational: at most one of if_gnt or d_gnt per cycle, and only when the corresponding req is high and reset is low.
REQ-020 Default priority: data over fetch.
REQ-021 starve_cnt increments when if_req=1 and if_gnt=0; clears on if_gnt or if_req=0; saturates at MAX_WAIT.
REQ-022 When starve_cnt==MAX_WAIT and if_req=1, fetch wins over data.
REQ-023 On a grant: mem_en=1; mem_addr, mem_we, mem_be and mem_wdata are driven from the winner (fetch: we=0, be=0, wdata=0); with no grant, all mem_* outputs are 0.
REQ-024 Response FSM states: IDLE, RESP_IF, RESP_D. Next state is RESP_IF after a fetch grant, RESP_D after a load grant, and IDLE otherwise (no grant or store grant).
REQ-025 In RESP_IF: if_rvalid=1 and if_rdata=mem_rdata. In RESP_D: d_rvalid=1 and d_rdata=mem_rdata. Read latency is exactly 1 cycle after the grant.
REQ-026 rdata outputs are 0 whenever the matching rvalid is 0.
REQ-027 A new grant is allowed in any state, including the cycle of a pending response, so throughput is one access per cycle.
REQ-028 Requesters hold req, addr, we, be and wdata stable until gnt; the arbiter performs no checking of this.
REQ-029 If both requesters are idle, the FSM returns to IDLE and all outputs are 0.

Reset
REQ-030 While reset=1: if_gnt=d_gnt=0, all mem_* outputs are 0, and no grant occurs.
REQ-031 After the reset edge: FSM=IDLE, starve_cnt=0, if_rvalid=d_rvalid=0, rdata outputs 0.
REQ-032 Reset during a pending response drops that response; no rvalid is issued in the following cycle.

Structure
REQ-033 The shared package mem_arb_pkg holds the response-state enum (IDLE, RESP_IF, RESP_D), owner encoding, and data/byte-enable width constants.
REQ-034 One sub-module, starve_counter (saturating counter with clear), is instantiated once; the rest of the logic is flat.

Verification
REQ-035 Fetch only: if_req=1, if_addr=0x004 -> if_gnt same cycle, mem_addr=0x004, if_rvalid next cycle with if_rdata equal to mem[0x004].
REQ-036 Simultaneous requests, MAX_WAIT=2, d_req held for 4 load cycles -> d_gnt in cycles 0 and 1, if_gnt in cycle 2, d_gnt in cycle 3.
REQ-037 Store with d_addr=0x010, d_wdata=0xDEADBEEF, d_be=4'hF -> mem_we=1 with matching fields, d_rvalid stays 0; a load of 0x010 next cycle returns 0xDEADBEEF.
REQ-038 Back-to-back: fetch grant then load grant in consecutive cycles -> if_rvalid and d_rvalid in consecutive cycles, each with correct data and never both high.
REQ-039 Reset asserted in the cycle after a load grant -> no d_rvalid, starve_cnt=0, and the first grant occurs in the first cycle after reset deasserts.
REQ-040 No requests for 10 cycles -> all outputs 0 and FSM remains IDLE.
